// File: rtl/ring_seq_pkg.sv
// Shared types and constants for the ring sequencing controller.
package ring_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int LAP_W = 8;

endpackage

// File: rtl/ring_seq_prescaler.sv
// Step prescaler: counts enabled cycles and flags the last cycle of each PRESCALE period.
module ring_seq_prescaler
    import ring_seq_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk_i,
    input  logic sys_rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    // A one-cycle period still needs a 1-bit register so the compare stays legal.
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_o = (cnt == TC);

    always_ff @(posedge clk_i) begin
        if (sys_rst_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= tick_o ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ring_seq_ctrl.sv
// One-hot ring sequencer with lap counting and start/stop/pause control.
// Optional feature: define RING_SEQ_STEP_EN to add step_i (single-step while paused).
module ring_seq_ctrl
    import ring_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk_i,
    input  logic             sys_rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic             dir_i,
    input  logic [7:0]       laps_i,
`ifdef RING_SEQ_STEP_EN
    input  logic             step_i,
`endif
    output logic [WIDTH-1:0] ring_o,
    output logic             step_o,
    output logic             busy_o,
    output logic             done_o
);

    // state | meaning
    // IDLE  | ring parked at bit0, waiting for start
    // RUN   | prescaler counting, ring rotates on each tick
    // PAUSE | prescaler and ring frozen
    // DONE  | one cycle, programmed laps finished

    localparam logic [WIDTH-1:0] RING_HOME = WIDTH'(1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   ring_q, ring_nxt, ring_rot;
    logic               dir_q, dir_nxt;
    logic [LAP_W-1:0]   laps_q, laps_nxt;
    logic [LAP_W-1:0]   lap_cnt, lap_nxt, lap_inc;
    logic               step_q, step_nxt;
    logic               busy_q, done_q;
    logic               adv;
    logic               presc_en, presc_clr, presc_tick;
    logic               lap_hit, lap_done;

    ring_seq_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i     (clk_i),
        .sys_rst_i (sys_rst_i),
        .clr_i     (presc_clr),
        .en_i      (presc_en),
        .tick_o    (presc_tick)
    );

    always_comb begin
        if (dir_q == DIR_DOWN) begin
            ring_rot = {ring_q[0], ring_q[WIDTH-1:1]};
        end else begin
            ring_rot = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
        end
    end

    // The ring is one-hot, so a rotation landing on bit0 closes a lap.
    assign lap_hit  = ring_rot[0];
    assign lap_inc  = lap_cnt + LAP_W'(1);
    assign lap_done = lap_hit && (laps_q != '0) && (lap_inc == laps_q);

    always_comb begin
        state_nxt = state;
        ring_nxt  = ring_q;
        dir_nxt   = dir_q;
        laps_nxt  = laps_q;
        lap_nxt   = lap_cnt;
        step_nxt  = 1'b0;
        adv       = 1'b0;
        presc_en  = 1'b0;
        presc_clr = 1'b0;

        case (state)
            IDLE: begin
                ring_nxt  = RING_HOME;
                presc_clr = 1'b1;
                if (start_i && !stop_i) begin
                    state_nxt = RUN;
                    dir_nxt   = dir_i;
                    laps_nxt  = laps_i;
                    lap_nxt   = '0;
                end
            end
            RUN, PAUSE: begin
                if (stop_i) begin
                    state_nxt = IDLE;
                    ring_nxt  = RING_HOME;
                end else if (pause_i) begin
                    state_nxt = PAUSE;
`ifdef RING_SEQ_STEP_EN
                    adv = (state == PAUSE) && step_i;
`endif
                end else begin
                    state_nxt = RUN;
                    presc_en  = 1'b1;
                    adv       = presc_tick;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ring_nxt  = RING_HOME;
            end
            default: begin
                state_nxt = IDLE;
                ring_nxt  = RING_HOME;
            end
        endcase

        if (adv) begin
            ring_nxt = ring_rot;
            step_nxt = 1'b1;
            if (lap_hit) begin
                lap_nxt = lap_inc;
            end
            if (lap_done) begin
                state_nxt = DONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sys_rst_i) begin
            state   <= IDLE;
            ring_q  <= RING_HOME;
            dir_q   <= DIR_UP;
            laps_q  <= '0;
            lap_cnt <= '0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ring_q  <= ring_nxt;
            dir_q   <= dir_nxt;
            laps_q  <= laps_nxt;
            lap_cnt <= lap_nxt;
            step_q  <= step_nxt;
            busy_q  <= (state_nxt == RUN) || (state_nxt == PAUSE);
            done_q  <= (state_nxt == DONE);
        end
    end

    assign ring_o = ring_q;
    assign step_o = step_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Bench for ring_seq_ctrl: a PRESCALE=4 and a PRESCALE=1 instance share stimulus and are
// compared every cycle against a timeline model (elapsed unpaused cycles -> step count).
module tb_ring_seq_ctrl;

    localparam int W    = 8;
    localparam int NDUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         sys_rst  = 1'b1;
    logic         start_in = 1'b0;
    logic         stop_in  = 1'b0;
    logic         pause_in = 1'b0;
    logic         dir_in   = 1'b0;
    logic         step_in  = 1'b0;
    logic [7:0]   laps_in  = 8'd0;

    logic [W-1:0] ring [NDUT];
    logic         stp  [NDUT];
    logic         busy [NDUT];
    logic         done [NDUT];

    ring_seq_ctrl #(.WIDTH(W), .PRESCALE(4)) u_dut (
        .clk_i     (clk),
        .sys_rst_i (sys_rst),
        .start_i   (start_in),
        .stop_i    (stop_in),
        .pause_i   (pause_in),
        .dir_i     (dir_in),
        .laps_i    (laps_in),
`ifdef RING_SEQ_STEP_EN
        .step_i    (step_in),
`endif
        .ring_o    (ring[0]),
        .step_o    (stp[0]),
        .busy_o    (busy[0]),
        .done_o    (done[0])
    );

    ring_seq_ctrl #(.WIDTH(W), .PRESCALE(1)) u_p1 (
        .clk_i     (clk),
        .sys_rst_i (sys_rst),
        .start_i   (start_in),
        .stop_i    (stop_in),
        .pause_i   (pause_in),
        .dir_i     (dir_in),
        .laps_i    (laps_in),
`ifdef RING_SEQ_STEP_EN
        .step_i    (step_in),
`endif
        .ring_o    (ring[1]),
        .step_o    (stp[1]),
        .busy_o    (busy[1]),
        .done_o    (done[1])
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Reference model: a run is a count of unpaused busy cycles; every PRESCALE of them
    // (or a manual step while paused) is one ring step, and laps*W steps finish the run.
    bit m_busy    [NDUT];
    bit m_done    [NDUT];
    bit m_step    [NDUT];
    bit m_paused  [NDUT];
    bit m_dir     [NDUT];
    int m_laps    [NDUT];
    int m_elapsed [NDUT];
    int m_steps   [NDUT];

    int c_busy, c_step, c_done, c1_busy, c1_step, c1_first, c1_last;
    logic [W-1:0] ring_at_done, first_ring;

    function automatic int presc_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [W-1:0] ring_of(input int steps, input bit dir);
        int pos;
        pos = steps % W;
        if (dir) pos = (W - pos) % W;
        ring_of = '0;
        ring_of[pos] = 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic advance(input int i);
        m_steps[i]++;
        m_step[i] = 1'b1;
        if (m_laps[i] != 0 && m_steps[i] == m_laps[i] * W) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NDUT; i++) begin
            bit was_done;
            was_done  = m_done[i];
            m_done[i] = 1'b0;
            m_step[i] = 1'b0;
            if (sys_rst) begin
                m_busy[i]    = 1'b0;
                m_paused[i]  = 1'b0;
                m_steps[i]   = 0;
                m_elapsed[i] = 0;
            end else if (m_busy[i]) begin
                if (stop_in) begin
                    m_busy[i]   = 1'b0;
                    m_paused[i] = 1'b0;
                    m_steps[i]  = 0;
                end else if (pause_in) begin
                    if (m_paused[i] && step_in) advance(i);
                    if (m_busy[i]) m_paused[i] = 1'b1;
                end else begin
                    m_paused[i] = 1'b0;
                    m_elapsed[i]++;
                    if (m_elapsed[i] % presc_of(i) == 0) advance(i);
                end
            end else if (!was_done && start_in && !stop_in) begin
                m_busy[i]    = 1'b1;
                m_dir[i]     = dir_in;
                m_laps[i]    = int'(laps_in);
                m_elapsed[i] = 0;
                m_steps[i]   = 0;
                m_paused[i]  = 1'b0;
            end
        end
    endtask

    task automatic clear_metrics();
        c_busy = 0; c_step = 0; c_done = 0;
        c1_busy = 0; c1_step = 0; c1_first = -1; c1_last = -1;
        ring_at_done = '0; first_ring = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("ring[%0d]", i), 32'(ring[i]), 32'(ring_of(m_steps[i], m_dir[i])));
            check($sformatf("step[%0d]", i), 32'(stp[i]),  32'(m_step[i]));
            check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_busy[i]));
            check($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
        end
        c_busy += int'(busy[0]);
        c_done += int'(done[0]);
        if (stp[0] === 1'b1) begin
            c_step++;
            if (c_step == 1) first_ring = ring[0];
        end
        if (done[0] === 1'b1) ring_at_done = ring[0];
        c1_busy += int'(busy[1]);
        if (stp[1] === 1'b1) begin
            c1_step++;
            if (c1_first < 0) c1_first = cyc;
            c1_last = cyc;
        end
        cyc++;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (c_done == 0 && n < budget) begin
            tick();
            n++;
        end
        check("wait_done", 32'(c_done != 0), 32'd1);
    endtask

    task automatic wait_steps(input int target, input int budget);
        int n;
        n = 0;
        while (c_step < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_steps", 32'(c_step), 32'(target));
    endtask

    initial begin
        clear_metrics();

        // reset
        sys_rst = 1'b1;
        tick();
        tick();
        check("rst_ring", 32'(ring[0]), 32'h01);
        check("rst_step", 32'(stp[0]),  32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        sys_rst = 1'b0;
        tick();

        // one lap upward
        clear_metrics();
        laps_in = 8'd1; dir_in = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        wait_done(200);
        repeat (3) tick();
        check("t1_busy_cycles", 32'(c_busy), 32'd32);
        check("t1_steps", 32'(c_step), 32'd8);
        check("t1_done_pulses", 32'(c_done), 32'd1);
        check("t1_ring_at_done", 32'(ring_at_done), 32'h01);
        check("p1_busy_cycles", 32'(c1_busy), 32'd8);
        check("p1_steps", 32'(c1_step), 32'd8);
        check("p1_step_span", 32'(c1_last - c1_first + 1), 32'd8);

        // two laps downward
        clear_metrics();
        laps_in = 8'd2; dir_in = 1'b1; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        wait_done(300);
        check("t2_first_ring", 32'(first_ring), 32'h80);
        check("t2_steps", 32'(c_step), 32'd16);
        check("t2_busy_cycles", 32'(c_busy), 32'd64);
        tick();

        // pause 10 cycles mid-run
        clear_metrics();
        laps_in = 8'd1; dir_in = 1'($urandom_range(0, 1)); start_in = 1'b1;
        tick();
        start_in = 1'b0;
        repeat (9) tick();
        pause_in = 1'b1;
        begin
            logic [W-1:0] held;
            held = ring_of(m_steps[0], m_dir[0]);
            for (int k = 0; k < 10; k++) begin
                tick();
                check("t3_ring_hold", 32'(ring[0]), 32'(held));
            end
        end
        pause_in = 1'b0;
        wait_done(200);
        check("t3_busy_cycles", 32'(c_busy), 32'd42);
        tick();

        // free-run, stop after the fifth step
        clear_metrics();
        laps_in = 8'd0; dir_in = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        wait_steps(5, 100);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        check("t4_stop_ring", 32'(ring[0]), 32'h01);
        check("t4_stop_busy", 32'(busy[0]), 32'd0);
        tick();
        check("t4_no_done", 32'(c_done), 32'd0);
        start_in = 1'b1; stop_in = 1'b1;
        tick();
        start_in = 1'b0; stop_in = 1'b0;
        tick();
        check("t4_start_stop_idle", 32'(busy[0]), 32'd0);

        // reset mid-run, then start re-asserted while running
        laps_in = 8'd2; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        repeat (20) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("t5_rst_ring", 32'(ring[0]), 32'h01);
        check("t5_rst_step", 32'(stp[0]),  32'd0);
        check("t5_rst_busy", 32'(busy[0]), 32'd0);
        check("t5_rst_done", 32'(done[0]), 32'd0);
        clear_metrics();
        laps_in = 8'd1; dir_in = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        repeat (5) tick();
        start_in = 1'b1;
        repeat (2) tick();
        start_in = 1'b0;
        wait_done(200);
        check("t5_busy_cycles", 32'(c_busy), 32'd32);

        // back-to-back: start held through DONE
        clear_metrics();
        tick();
        laps_in = 8'd1; start_in = 1'b1;
        tick();
        wait_done(200);
        tick();
        check("b2b_idle_gap", 32'(busy[0]), 32'd0);
        tick();
        check("b2b_restart", 32'(busy[0]), 32'd1);
        start_in = 1'b0; stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        tick();

`ifdef RING_SEQ_STEP_EN
        // manual steps while paused
        clear_metrics();
        laps_in = 8'd1; dir_in = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0; pause_in = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            step_in = 1'b1;
            tick();
            step_in = 1'b0;
            tick();
        end
        check("t6_step_ring", 32'(ring[0]), 32'h08);
        check("t6_steps", 32'(c_step), 32'd3);
        pause_in = 1'b0;
        wait_done(200);
        check("t6_busy_cycles", 32'(c_busy), 32'd27);
        tick();
`endif

        // randomized traffic against the model
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 150; k++) begin
                start_in = ($urandom_range(0, 3) == 0);
                stop_in  = ($urandom_range(0, 79) == 0);
                pause_in = ($urandom_range(0, 5) == 0);
                dir_in   = 1'($urandom_range(0, 1));
                laps_in  = 8'($urandom_range(0, 2));
`ifdef RING_SEQ_STEP_EN
                step_in  = ($urandom_range(0, 2) == 0);
`endif
                tick();
            end
        end

        start_in = 1'b0; pause_in = 1'b0; step_in = 1'b0; stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
